norm32_iter: RTL and testbench
==============================

# norm32_iter

Iterative 32-bit normalizer for the GPU/DSP ALU shifter path. It is the inverse of the barrel shift: given an operand, it computes how far left the operand must be shifted to normalize it, and returns both the count and the shifted value. The count feeds the barrel shifter's `sft` field and the NORMI result; it is computed by a 5-step binary search, one step per clock, behind valid/ready handshakes.

## Interface
- `W`, default 32: operand width. Fixed at 32; the design does not scale it.
- `CW`, default 6: count width. Holds 0..32.
- `sys_clk`  in  1  system clock; all state changes on its rising edge.
- `resetl`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  block can accept an operand; high only in IDLE.
- `a`  in  32  operand.
- `sgn`  in  1  signed mode select. Present only with `NORM32_SIGNED_EN`.
- `out_valid`  out  1  result present; high only in DONE.
- `out_ready`  in  1  consumer accepts the result.
- `cnt`  out  6  left-shift count.
- `z`  out  32  `a << cnt`.
- `zero`  out  1  operand was 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch `a` into `val` and latch the search word `t`. Clear the count accumulator `acc`, set step `k`=4, go to RUN.
  - Operand is ignored when `in_valid`=0.
- Search word `t`:
  - Unsigned: `t`=`a`.
  - Signed: `t`={`a[30:0]` ^ {31{`a[31]`}}, 1'b1}.
- RUN, one step per cycle for k=4,3,2,1,0, with s=2^k:
  - If `t[31:32-s]`==0: `t`<<=s, `val`<<=s, `acc`+=s.
  - After k=0, go to DONE.
- Entering DONE (same edge as the k=0 step, using the post-step values):
  - Unsigned with `t[31]`==0 (zero operand): `cnt`=32, `z`=0, `zero`=1.
  - Otherwise: `cnt`=`acc` (0..31), `z`=`val`.
  - `zero`=1 exactly when the operand was 0, in both modes.
- Signed results:
  - `cnt` is the number of redundant sign bits.
  - `z` has `z[31]`!=`z[30]` unless the operand is 0 or all-ones; for those two operands `cnt`=31.
  - The count never exceeds 31 in signed mode.
- DONE:
  - `out_valid`=1, and `cnt`/`z`/`zero` stay stable until the handshake.
  - On `out_ready`: return to IDLE.
  - `in_valid` is ignored in DONE and RUN.
- Arithmetic:
  - `acc` is 6 bits and cannot overflow; its maximum is 31 before the zero fix-up.
  - All shifts are logical with zero fill.

## Timing
- Accept at edge E0. Steps run at E1..E5. `out_valid` rises after E5.
- Minimum latency from accept to `out_valid` is 5 cycles.
- With `out_ready` tied high, the handshake completes at E6 and `in_ready` returns after E6. Maximum throughput is 1 operand per 6 cycles.
- `in_ready` and `out_valid` are registered-state decodes only; there is no combinational path from inputs to them.
- `out_ready` held low: the result is held indefinitely.
- Reset values, and the behaviour when `resetl` falls at any point including mid-RUN:
  - Immediately: state=IDLE, `in_ready`=1, `out_valid`=0, `cnt`=0, `z`=0, `zero`=0.
  - Any partial result is discarded.
- The first accept is possible on the first edge after `resetl` deasserts.

## Configuration
- `NORM32_SIGNED_EN` defined: the `sgn` port exists; `sgn`=1 selects signed normalization. `sgn` is sampled only at accept.
- Undefined: there is no `sgn` port, and the block is unsigned only, with zero count 32.

## Structure
- Package `jag_norm_pkg` holds:
  - the state enum {IDLE, RUN, DONE};
  - constants `NORM_W`=32, `NORM_CW`=6 and `NORM_STEPS`=5.
- Sub-module `norm32_step`:
  - Purely combinational.
  - Inputs: `t`, `val`, `acc`, `k`. Outputs: next `t`, next `val`, next `acc`.
  - Instantiated once in the FSM datapath.

## Test plan
- Unsigned `a`=0x00010000 -> `cnt`=15, `z`=0x80000000, `zero`=0; `out_valid` exactly 5 cycles after accept.
- Unsigned `a`=0 -> `cnt`=32, `z`=0, `zero`=1. `a`=0x80000000 -> `cnt`=0, `z`=0x80000000.
- Signed (`NORM32_SIGNED_EN`, `sgn`=1):
  - `a`=0xFFFF8000 -> `cnt`=16, `z`=0x80000000.
  - `a`=0x00000001 -> `cnt`=30, `z`=0x40000000.
  - `a`=0xFFFFFFFF -> `cnt`=31, `zero`=0.
- Backpressure: hold `out_ready`=0 for 10 cycles -> outputs stable, `in_ready`=0, and a new `in_valid` is ignored. Release -> IDLE one edge later.
- Reset mid-RUN (after E2): `resetl` low -> `out_valid`=0 and `in_ready`=1 immediately. The next operand 0x00000100 yields `cnt`=23.
- Back-to-back with `out_ready` high: 100 random operands match the reference clz model, at 6 cycles per operand.

Source files
------------

// File: rtl/jag_norm_pkg.sv
// Shared types and constants for the iterative 32-bit normalizer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jag_norm_pkg;

  localparam int NORM_W     = 32;
  localparam int NORM_CW    = 6;
  localparam int NORM_STEPS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/norm32_step.sv
// One binary-search step of the normalizer: if the top 2^k bits of the
// search word are all zero, shift search word and value left by 2^k and
// add 2^k to the count accumulator.
// Latency: combinational. Backpressure: none (pure function).
// Ports: t/val/acc/k current search state in; t_nxt/val_nxt/acc_nxt out.
module norm32_step
  import jag_norm_pkg::*;
(
  input  logic [NORM_W-1:0]  t,
  input  logic [NORM_W-1:0]  val,
  input  logic [NORM_CW-1:0] acc,
  input  logic [2:0]         k,
  output logic [NORM_W-1:0]  t_nxt,
  output logic [NORM_W-1:0]  val_nxt,
  output logic [NORM_CW-1:0] acc_nxt
);

  logic              w_hit;
  logic [NORM_CW-1:0] w_s;

  assign w_s = NORM_CW'(1) << k;

  // Test of t[31:32-s] == 0 written per step so every slice is constant.
  always_comb begin
    w_hit = 1'b0;
    case (k)
      3'd4:    w_hit = (t[31:16] == 16'd0);
      3'd3:    w_hit = (t[31:24] == 8'd0);
      3'd2:    w_hit = (t[31:28] == 4'd0);
      3'd1:    w_hit = (t[31:30] == 2'd0);
      3'd0:    w_hit = (t[31] == 1'b0);
      default: w_hit = 1'b0;
    endcase
  end

  assign t_nxt   = w_hit ? (t << w_s)   : t;
  assign val_nxt = w_hit ? (val << w_s) : val;
  assign acc_nxt = w_hit ? (acc + w_s)  : acc;

endmodule

// File: rtl/norm32_iter.sv
// Iterative 32-bit normalizer: left-shift count (cnt) and normalized value
// (z = a << cnt) via a 5-step binary search, one step per clock.
// Latency: 5 cycles accept-to-out_valid; next accept possible after the
// output handshake. Backpressure: result held in DONE until out_ready.
// Optional feature macro: NORM32_SIGNED_EN adds the sgn port (signed mode,
// count of redundant sign bits, max 31).
// Ports: sys_clk, resetl (async active-low); in_valid/in_ready/a[/sgn]
// operand handshake; out_valid/out_ready/cnt/z/zero result handshake.
module norm32_iter
  import jag_norm_pkg::*;
#(
  parameter int W  = NORM_W,
  parameter int CW = NORM_CW
) (
  input  logic          sys_clk,
  input  logic          resetl,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
`ifdef NORM32_SIGNED_EN
  input  logic          sgn,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] cnt,
  output logic [W-1:0]  z,
  output logic          zero
);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [W-1:0]  r_t;
  logic [W-1:0]  r_val;
  logic [CW-1:0] r_acc;
  logic [2:0]    r_k;
  logic          r_azero;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_z;
  logic          r_zero;

  logic [W-1:0]  w_t_init;
  logic          w_signed;
  logic [W-1:0]  w_t_nxt;
  logic [W-1:0]  w_val_nxt;
  logic [CW-1:0] w_acc_nxt;
  logic          w_accept;

`ifdef NORM32_SIGNED_EN
  logic          r_sgn;

  // Signed search word: redundant sign bits become leading zeros; the
  // forced LSB caps the count at 31 for 0 and all-ones.
  assign w_t_init = sgn ? {a[30:0] ^ {31{a[31]}}, 1'b1} : a;
  assign w_signed = r_sgn;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_sgn <= 1'b0;
    end else if (w_accept) begin
      r_sgn <= sgn;
    end
  end
`else
  assign w_t_init = a;
  assign w_signed = 1'b0;
`endif

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign cnt       = r_cnt;
  assign z         = r_z;
  assign zero      = r_zero;

  norm32_step u_step (
    .t       (r_t),
    .val     (r_val),
    .acc     (r_acc),
    .k       (r_k),
    .t_nxt   (w_t_nxt),
    .val_nxt (w_val_nxt),
    .acc_nxt (w_acc_nxt)
  );

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)   w_state_nxt = RUN;
      RUN:     if (r_k == 3'd0) w_state_nxt = DONE;
      DONE:    if (out_ready)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_t     <= '0;
      r_val   <= '0;
      r_acc   <= '0;
      r_k     <= '0;
      r_azero <= 1'b0;
      r_cnt   <= '0;
      r_z     <= '0;
      r_zero  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_t     <= w_t_init;
        r_val   <= a;
        r_acc   <= '0;
        r_k     <= 3'(NORM_STEPS - 1);
        r_azero <= (a == '0);
      end else if (r_state == RUN) begin
        r_t   <= w_t_nxt;
        r_val <= w_val_nxt;
        r_acc <= w_acc_nxt;
        if (r_k != 3'd0) begin
          r_k <= r_k - 3'd1;
        end else begin
          // Final step: publish using the post-step values. In unsigned
          // mode a search word still without a top 1 means the operand was 0.
          if (!w_signed && !w_t_nxt[W-1]) begin
            r_cnt <= CW'(W);
            r_z   <= '0;
          end else begin
            r_cnt <= w_acc_nxt;
            r_z   <= w_val_nxt;
          end
          r_zero <= r_azero;
        end
      end
    end
  end

endmodule

// File: tb/tb_norm32_iter.sv
module tb_norm32_iter;

  typedef struct {
    logic [5:0]  cnt;
    logic [31:0] z;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic        sgn;
    logic [5:0]  cnt;
    logic [31:0] z;
    logic        zero;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        resetl  = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'd0;
`ifdef NORM32_SIGNED_EN
  logic        sgn_drv = 1'b0;
`endif
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  cnt;
  logic [31:0] z;
  logic        zero;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t vecs[$];

  always #5 sys_clk = ~sys_clk;

  norm32_iter dut (
    .sys_clk   (sys_clk),
    .resetl    (resetl),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
`ifdef NORM32_SIGNED_EN
    .sgn       (sgn_drv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt       (cnt),
    .z         (z),
    .zero      (zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: straightforward bit scan, independent of the binary search.
  function automatic exp_t model(input logic [31:0] av, input logic sv);
    exp_t r;
    int   n;
    n = 0;
    if (!sv) begin
      while (n < 32 && av[31-n] == 1'b0) n++;
    end else begin
      while (n < 31 && av[30-n] == av[31]) n++;
    end
    r.cnt  = 6'(n);
    r.z    = (n == 32) ? 32'd0 : (av << n);
    r.zero = (av == 32'd0);
    return r;
  endfunction

  // Scoreboard: compare every completed output handshake.
  always @(negedge sys_clk) begin
    if (resetl && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(cnt), 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("cnt", 64'(cnt), 64'(e.cnt));
        chk("z", 64'(z), 64'(e.z));
        chk("zero", 64'(zero), 64'(e.zero));
      end
    end
  end

  // Drive one operand; optionally check accept->out_valid latency (5) and,
  // with out_ready high, accept->in_ready return (6).
  task automatic run_op(input logic [31:0] av, input logic sv, input exp_t e, input bit timing);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge sys_clk); #1; n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    a = av;
`ifdef NORM32_SIGNED_EN
    sgn_drv = sv;
`endif
    in_valid = 1'b1;
    sb.push_back(e);
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge sys_clk); #1; n++;
    end
    if (timing) chk("latency", 64'(n), 64'd5);
    else if (!out_valid) chk("out_valid_timeout", 64'(out_valid), 64'd1);
    if (out_ready) begin
      while (!in_ready && n < 40) begin
        @(posedge sys_clk); #1; n++;
      end
      if (timing) chk("turnaround", 64'(n), 64'd6);
    end
  endtask

  initial begin
    exp_t e;
    logic [31:0] r_a;
    logic        r_s;

    vecs.push_back('{32'h0001_0000, 1'b0, 6'd15, 32'h8000_0000, 1'b0});
    vecs.push_back('{32'h0000_0000, 1'b0, 6'd32, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h8000_0000, 1'b0, 6'd0,  32'h8000_0000, 1'b0});
    vecs.push_back('{32'h0000_0001, 1'b0, 6'd31, 32'h8000_0000, 1'b0});
    vecs.push_back('{32'h1234_5678, 1'b0, 6'd3,  32'h91A2_B3C0, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 1'b0, 6'd0,  32'hFFFF_FFFF, 1'b0});
`ifdef NORM32_SIGNED_EN
    vecs.push_back('{32'hFFFF_8000, 1'b1, 6'd16, 32'h8000_0000, 1'b0});
    vecs.push_back('{32'h0000_0001, 1'b1, 6'd30, 32'h4000_0000, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 1'b1, 6'd31, 32'h8000_0000, 1'b0});
    vecs.push_back('{32'h0000_0000, 1'b1, 6'd31, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h8000_0000, 1'b1, 6'd0,  32'h8000_0000, 1'b0});
`endif

    // Reset state (asynchronous, visible before any clock edge).
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_z", 64'(z), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    #20;
    resetl = 1'b1;
    @(posedge sys_clk); #1;

    // Directed vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      e.cnt = vecs[i].cnt; e.z = vecs[i].z; e.zero = vecs[i].zero;
      run_op(vecs[i].a, vecs[i].sgn, e, 1'b1);
    end

    // Backpressure: result held, new operand ignored.
    out_ready = 1'b0;
    e.cnt = 6'd15; e.z = 32'h8000_0000; e.zero = 1'b0;
    run_op(32'h0001_0000, 1'b0, e, 1'b1);
    for (int i = 0; i < 10; i++) begin
      a = 32'hDEAD_BEEF;
      in_valid = 1'b1;
      @(posedge sys_clk); #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_cnt", 64'(cnt), 64'd15);
      chk("bp_z", 64'(z), 64'h8000_0000);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);

    // Reset mid-RUN after E2: partial result discarded.
    a = 32'h0000_0F00;
    in_valid = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    @(posedge sys_clk);
    @(posedge sys_clk); #1;
    resetl = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_cnt", 64'(cnt), 64'd0);
    @(posedge sys_clk); #3;
    resetl = 1'b1;
    @(posedge sys_clk); #1;
    e.cnt = 6'd23; e.z = 32'h8000_0000; e.zero = 1'b0;
    run_op(32'h0000_0100, 1'b0, e, 1'b1);

    // Back-to-back random operands against the reference model.
    for (int i = 0; i < 100; i++) begin
      r_a = $urandom;
      if (i % 4 == 1) r_a = r_a >> $urandom_range(31, 0);
      if (i % 4 == 2) r_a = ~(32'hFFFF_FFFF >> $urandom_range(31, 0)) | (r_a >> 28);
`ifdef NORM32_SIGNED_EN
      r_s = 1'($urandom_range(1, 0));
`else
      r_s = 1'b0;
`endif
      run_op(r_a, r_s, model(r_a, r_s), 1'b1);
    end

    repeat (3) @(posedge sys_clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
